// File: rtl/decoder_logic_unit_if.sv
// decoder_logic_unit_if: config, input and result signals of the decoder logic unit.
interface decoder_logic_unit_if #(parameter int N_IN = 2);
    localparam int TT_W = 1 << N_IN;
    logic            cfg_load;
    logic [TT_W-1:0] cfg_tt;
    logic            cfg_preset_en;
    logic [2:0]      cfg_preset;
    logic            in_valid;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_y;
    logic [TT_W-1:0] out_onehot;
    modport master (
        output cfg_load, cfg_tt, cfg_preset_en, cfg_preset, in_valid, in_data,
        input  out_valid, out_y, out_onehot
    );
    modport slave (
        input  cfg_load, cfg_tt, cfg_preset_en, cfg_preset, in_valid, in_data,
        output out_valid, out_y, out_onehot
    );
endinterface

// File: rtl/decoder_logic_unit.sv
// decoder_logic_unit: N-input boolean function via one-hot decode, programmable truth table and OR reduce.
module decoder_logic_unit #(
    parameter int N_IN = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    decoder_logic_unit_if.slave bus
);
    localparam int TT_W = 1 << N_IN;
    localparam logic [TT_W-1:0] ONE = TT_W'(1);
    logic [TT_W-1:0] xor_tt, preset_tt, tt_reg_d, tt_reg_q, tt_s1_q, onehot_q, out_oh_q;
    logic            v1_q, out_valid_q, out_y_q;
    for (genvar k = 0; k < TT_W; k++) begin : g_par
        assign xor_tt[k] = ^(6'(k));
    end
    always_comb begin
        case (bus.cfg_preset)
            3'd0:    preset_tt = ONE << (TT_W - 1);
            3'd1:    preset_tt = ~ONE;
            3'd2:    preset_tt = ~(ONE << (TT_W - 1));
            3'd3:    preset_tt = ONE;
            3'd4:    preset_tt = xor_tt;
            3'd5:    preset_tt = ~xor_tt;
            3'd6:    preset_tt = '0;
            default: preset_tt = '1;
        endcase
    end
    // a full table load overrides a preset request on the same edge
    assign tt_reg_d = bus.cfg_load ? bus.cfg_tt : bus.cfg_preset_en ? preset_tt : tt_reg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_reg_q    <= ~ONE;
            v1_q        <= 1'b0;
            onehot_q    <= '0;
            tt_s1_q     <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= 1'b0;
            out_oh_q    <= '0;
        end else begin
            tt_reg_q    <= tt_reg_d;
            v1_q        <= bus.in_valid;
            out_valid_q <= v1_q;
            if (bus.in_valid) begin
                onehot_q <= ONE << bus.in_data;
                tt_s1_q  <= tt_reg_q;
            end
            if (v1_q) begin
                out_y_q  <= |(onehot_q & tt_s1_q);
                out_oh_q <= onehot_q;
            end
        end
    end
    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_onehot = out_oh_q;
endmodule
